// File: rtl/alu_ctrl_seq_if.sv
// Request/result bundle between decode and the sequenced ALU control block.
// master = decode/consumer side, slave = alu_ctrl_seq.
interface alu_ctrl_seq_if #(
    parameter int OP_W = 3
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      ALUOp;
    logic [10:0]     OpcodeField;
    logic            out_valid;
    logic            out_ready;
    logic [OP_W-1:0] operation;
    logic            busy;
    logic            mc_start;
    logic            illegal;

    modport master (
        output flush, in_valid, ALUOp, OpcodeField, out_ready,
        input  in_ready, out_valid, operation, busy, mc_start, illegal
    );

    modport slave (
        input  flush, in_valid, ALUOp, OpcodeField, out_ready,
        output in_ready, out_valid, operation, busy, mc_start, illegal
    );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with valid/ready handshake; MUL and SDIV are
// held for a parametrised number of cycles so the stall unit can see busy.
module alu_ctrl_seq #(
    parameter int OP_W    = 3,
    parameter int MUL_LAT = 4,
    parameter int DIV_EN  = 1,
    parameter int DIV_LAT = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    alu_ctrl_seq_if.slave  bus
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    localparam logic [2:0] OP_PASSB = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_DIV   = 3'b101;
    localparam logic [2:0] OP_LSL   = 3'b110;
    localparam logic [2:0] OP_LSR   = 3'b111;

    typedef enum logic [1:0] {IDLE, MULTI, DONE} state_e;

    state_e           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             ill_q, ill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mc_start_q, mc_start_d;

    logic [OP_W-1:0]  dec_op;
    logic             dec_ill;
    logic             dec_multi;
    logic [CNT_W-1:0] dec_cnt;
    logic             in_ready;
    logic             accept;

    // NOTE: every signal written in always_comb gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        dec_op    = OP_W'(OP_PASSB);
        dec_ill   = 1'b0;
        dec_multi = 1'b0;
        dec_cnt   = '0;
        if (bus.ALUOp == 2'b00) begin
            dec_op = OP_W'(OP_ADD);
        end else if (bus.ALUOp[0]) begin
            dec_op = OP_W'(OP_PASSB);
        end else begin
            casez (bus.OpcodeField)
                11'b10101011000, 11'b11111000010,
                11'b11111000000, 11'b1001000100?: dec_op = OP_W'(OP_ADD);
                11'b11101011000:                  dec_op = OP_W'(OP_SUB);
                11'b10001010000, 11'b01010100???: dec_op = OP_W'(OP_PASSB);
                11'b11010011011:                  dec_op = OP_W'(OP_LSL);
                11'b11010011010:                  dec_op = OP_W'(OP_LSR);
                11'b10011011000: begin
                    dec_op    = OP_W'(OP_MUL);
                    dec_multi = 1'b1;
                    dec_cnt   = CNT_W'(MUL_LAT - 1);
                end
                11'b10011010110: begin
                    if (DIV_EN != 0) begin
                        dec_op    = OP_W'(OP_DIV);
                        dec_multi = 1'b1;
                        dec_cnt   = CNT_W'(DIV_LAT - 1);
                    end else begin
                        dec_ill = 1'b1;
                    end
                end
                default: dec_ill = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        ill_d      = ill_q;
        cnt_d      = cnt_q;
        mc_start_d = 1'b0;
        in_ready   = 1'b0;

        case (state_q)
            IDLE:  in_ready = 1'b1;
            MULTI: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DONE: begin
                in_ready = bus.out_ready;
                if (bus.out_ready && !bus.in_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.flush) in_ready = 1'b0;
        accept = in_ready && bus.in_valid;

        // Acceptance in DONE overrides the return to IDLE: back-to-back issue.
        if (accept) begin
            op_d  = dec_op;
            ill_d = dec_ill;
            if (dec_multi) begin
                state_d    = MULTI;
                cnt_d      = dec_cnt;
                mc_start_d = 1'b1;
            end else begin
                state_d = DONE;
            end
        end

        if (bus.flush) begin
            state_d    = IDLE;
            cnt_d      = '0;
            mc_start_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            ill_q      <= 1'b0;
            cnt_q      <= '0;
            mc_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            ill_q      <= ill_d;
            cnt_q      <= cnt_d;
            mc_start_q <= mc_start_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == MULTI);
    assign bus.mc_start  = mc_start_q;
    assign bus.operation = op_q;
    assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: decode table sweep with scoreboard,
// plus hand-written handshake, flush and reset sequences.
module tb_alu_ctrl_seq;
    localparam int OP_W = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    alu_ctrl_seq_if #(.OP_W(OP_W)) bus ();
    alu_ctrl_seq_if #(.OP_W(OP_W)) bus1 ();

    alu_ctrl_seq #(.OP_W(OP_W), .MUL_LAT(4), .DIV_EN(1), .DIV_LAT(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );
    alu_ctrl_seq #(.OP_W(OP_W), .MUL_LAT(1), .DIV_EN(0), .DIV_LAT(16)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    typedef struct {
        logic [1:0]  aluop;
        logic [10:0] opc;
        logic [2:0]  op;
        logic        ill;
        int          lat;
    } vec_t;

    typedef struct {
        logic [2:0] op;
        logic       ill;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every result handed to the consumer must match the oldest
    // expectation pushed when its request was accepted.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_result", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("sb_op", 32'(bus.operation), 32'(e.op));
                check("sb_illegal", 32'(bus.illegal), 32'(e.ill));
            end
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        int k;
        int nbusy;
        int nmc;
        int nrdy;
        @(negedge clk);
        bus.ALUOp       = v.aluop;
        bus.OpcodeField = v.opc;
        bus.in_valid    = 1'b1;
        #1;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        check($sformatf("v%0d_accept", idx), 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        sb_q.push_back('{v.op, v.ill});
        #1;
        bus.in_valid = 1'b0;
        k = 1; nbusy = 0; nmc = 0; nrdy = 0;
        while (!bus.out_valid && k < 100) begin
            if (bus.busy)     nbusy++;
            if (bus.mc_start) nmc++;
            if (bus.in_ready) nrdy++;
            tick();
            k++;
        end
        check($sformatf("v%0d_latency", idx), 32'(k), 32'(v.lat));
        check($sformatf("v%0d_busy_cycles", idx), 32'(nbusy), 32'(v.lat - 1));
        check($sformatf("v%0d_mc_start", idx), 32'(nmc), (v.lat > 1) ? 32'd1 : 32'd0);
        check($sformatf("v%0d_in_ready_busy", idx), 32'(nrdy), 32'd0);
        tick();
        check($sformatf("v%0d_out_valid_drop", idx), 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nov;
        int nmc;

        vecs.push_back('{2'b00, 11'b11101011000, 3'b010, 1'b0, 1});
        vecs.push_back('{2'b01, 11'b11101011000, 3'b000, 1'b0, 1});
        vecs.push_back('{2'b11, 11'b10011011000, 3'b000, 1'b0, 1});
        vecs.push_back('{2'b10, 11'b10101011000, 3'b010, 1'b0, 1});
        vecs.push_back('{2'b10, 11'b11111000010, 3'b010, 1'b0, 1});
        vecs.push_back('{2'b10, 11'b11111000000, 3'b010, 1'b0, 1});
        vecs.push_back('{2'b10, 11'b10010001001, 3'b010, 1'b0, 1});
        vecs.push_back('{2'b10, 11'b10010001000, 3'b010, 1'b0, 1});
        vecs.push_back('{2'b10, 11'b11101011000, 3'b011, 1'b0, 1});
        vecs.push_back('{2'b10, 11'b10001010000, 3'b000, 1'b0, 1});
        vecs.push_back('{2'b10, 11'b01010100101, 3'b000, 1'b0, 1});
        vecs.push_back('{2'b10, 11'b11010011011, 3'b110, 1'b0, 1});
        vecs.push_back('{2'b10, 11'b11010011010, 3'b111, 1'b0, 1});
        vecs.push_back('{2'b10, 11'b10011011000, 3'b100, 1'b0, 5});
        vecs.push_back('{2'b10, 11'b10011010110, 3'b101, 1'b0, 17});
        vecs.push_back('{2'b10, 11'b00000000000, 3'b000, 1'b1, 1});
        vecs.push_back('{2'b10, 11'b10010001010, 3'b000, 1'b1, 1});

        bus.flush = 1'b0;  bus.in_valid = 1'b0;  bus.ALUOp = 2'b00;
        bus.OpcodeField = '0;  bus.out_ready = 1'b1;
        bus1.flush = 1'b0; bus1.in_valid = 1'b0; bus1.ALUOp = 2'b00;
        bus1.OpcodeField = '0; bus1.out_ready = 1'b1;

        repeat (2) tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_operation", 32'(bus.operation), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_mc_start", 32'(bus.mc_start), 32'd0);
        check("rst_illegal", 32'(bus.illegal), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Back-to-back issue with the consumer always ready.
        @(negedge clk);
        bus.ALUOp = 2'b00; bus.in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back('{3'b010, 1'b0});
        #1;
        bus.ALUOp = 2'b01;
        check("b2b_first_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_first_op", 32'(bus.operation), 32'd2);
        check("b2b_second_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        sb_q.push_back('{3'b000, 1'b0});
        #1;
        bus.in_valid = 1'b0;
        check("b2b_second_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_second_op", 32'(bus.operation), 32'd0);
        tick();
        check("b2b_idle", 32'(bus.out_valid), 32'd0);

        // Consumer stalls for 3 cycles: result held, next request blocked.
        @(negedge clk);
        bus.out_ready = 1'b0; bus.ALUOp = 2'b00; bus.in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back('{3'b010, 1'b0});
        #1;
        bus.ALUOp = 2'b01;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall%0d_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("stall%0d_op", i), 32'(bus.operation), 32'd2);
            check($sformatf("stall%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("stall_release_ready", 32'(bus.in_ready), 32'd1);
        check("stall_release_op", 32'(bus.operation), 32'd2);
        @(posedge clk);
        sb_q.push_back('{3'b000, 1'b0});
        #1;
        bus.in_valid = 1'b0;
        check("stall_second_op", 32'(bus.operation), 32'd0);
        check("stall_second_valid", 32'(bus.out_valid), 32'd1);
        tick();
        check("stall_idle", 32'(bus.out_valid), 32'd0);

        // Flush two cycles into a divide: no result, no second launch.
        @(negedge clk);
        bus.ALUOp = 2'b10; bus.OpcodeField = 11'b10011010110; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("flush_busy_c1", 32'(bus.busy), 32'd1);
        tick();
        check("flush_busy_c2", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.ALUOp = 2'b00;
        #1;
        check("flush_in_ready_low", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        #1;
        check("flush_busy_drop", 32'(bus.busy), 32'd0);
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        nov = 0; nmc = 0;
        for (int i = 0; i < 25; i++) begin
            if (bus.out_valid) nov++;
            if (bus.mc_start)  nmc++;
            tick();
        end
        check("flush_no_result", 32'(nov), 32'd0);
        check("flush_no_mc_start", 32'(nmc), 32'd0);

        // Flush while idle blocks a presented request.
        @(negedge clk);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.ALUOp = 2'b00;
        #1;
        check("flush_idle_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        check("flush_idle_no_result", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        bus.ALUOp = 2'b10; bus.OpcodeField = 11'b10011011000; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        tick();
        check("rmid_busy_before", 32'(bus.busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rmid_out_valid", 32'(bus.out_valid), 32'd0);
        check("rmid_busy", 32'(bus.busy), 32'd0);
        check("rmid_mc_start", 32'(bus.mc_start), 32'd0);
        check("rmid_illegal", 32'(bus.illegal), 32'd0);
        check("rmid_operation", 32'(bus.operation), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rmid_in_ready", 32'(bus.in_ready), 32'd1);
        nov = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid) nov++;
            tick();
        end
        check("rmid_no_result", 32'(nov), 32'd0);

        // Second instance: SDIV illegal when divide disabled, MUL_LAT=1.
        @(negedge clk);
        bus1.ALUOp = 2'b10; bus1.OpcodeField = 11'b10011010110; bus1.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        check("nodiv_valid", 32'(bus1.out_valid), 32'd1);
        check("nodiv_op", 32'(bus1.operation), 32'd0);
        check("nodiv_illegal", 32'(bus1.illegal), 32'd1);
        check("nodiv_busy", 32'(bus1.busy), 32'd0);
        tick();
        check("nodiv_drop", 32'(bus1.out_valid), 32'd0);

        @(negedge clk);
        bus1.OpcodeField = 11'b10011011000; bus1.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        check("mul1_busy", 32'(bus1.busy), 32'd1);
        check("mul1_mc_start", 32'(bus1.mc_start), 32'd1);
        check("mul1_not_valid", 32'(bus1.out_valid), 32'd0);
        tick();
        check("mul1_valid", 32'(bus1.out_valid), 32'd1);
        check("mul1_op", 32'(bus1.operation), 32'd4);
        check("mul1_illegal", 32'(bus1.illegal), 32'd0);
        check("mul1_busy_drop", 32'(bus1.busy), 32'd0);
        check("mul1_mc_once", 32'(bus1.mc_start), 32'd0);

        repeat (2) tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
